// File: rtl/int_ctrl.sv
// int_ctrl: four-line interrupt controller driving the datapath's one-hot
// interrupt-entry strobe. Requests are edge-latched, gated by a per-line mask
// and a global enable, and taken by fixed priority (bit 0 highest). The
// in-service line is tracked until the ISR signals return.
//
// Build option: define INT_CTRL_NEST_EN to let a higher-priority eligible
// line preempt the one in service. Left undefined, SERVICE is left only on
// reti and at most one in-service bit is ever set.
module int_ctrl #(
    parameter int NLINES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NLINES-1:0] irq,
    input  logic              mask_we,
    input  logic [NLINES-1:0] mask_in,
    input  logic              ei,
    input  logic              di,
    input  logic              reti,
    output logic [NLINES-1:0] ie,
    output logic [NLINES-1:0] isr,
    output logic [NLINES-1:0] pending,
    output logic              gie,
    output logic              busy
);

    localparam logic [NLINES-1:0] ZERO = {NLINES{1'b0}};
    localparam logic [NLINES-1:0] ONE  = {{(NLINES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            state_r;
    logic [NLINES-1:0] irq_q;
    logic [NLINES-1:0] mask_r;
    logic [NLINES-1:0] win_r;

    logic [NLINES-1:0] edge_s;
    logic [NLINES-1:0] elig_s;
    logic [NLINES-1:0] win_s;
    logic [NLINES-1:0] isr_top_s;
    logic [NLINES-1:0] clear_s;
    logic [NLINES-1:0] isr_next_s;
`ifdef INT_CTRL_NEST_EN
    logic              preempt_s;
`endif

    // Isolate the lowest set bit; lower index means higher priority, so this
    // is both the priority winner and the highest-priority in-service line.
    function automatic logic [NLINES-1:0] lowest_onehot(input logic [NLINES-1:0] v);
        lowest_onehot = v & (~v + ONE);
    endfunction

    // Edge detection, eligibility, priority pick and next in-service value.
    always_comb begin
        edge_s     = irq & ~irq_q;
        elig_s     = pending & mask_r & {NLINES{gie}};
        win_s      = lowest_onehot(elig_s);
        isr_top_s  = lowest_onehot(isr);
        isr_next_s = isr;
        if (state_r == ST_TAKE) begin
            clear_s = win_r;
        end else begin
            clear_s = ZERO;
        end
`ifdef INT_CTRL_NEST_EN
        // One-hot compare: a smaller value is a lower index, i.e. higher priority.
        preempt_s = (win_s != ZERO) && (win_s < isr_top_s);
`endif
        case (state_r)
            ST_TAKE: begin
                isr_next_s = isr | win_r;
            end
            ST_SERVICE: begin
                if (reti) begin
                    isr_next_s = isr & ~isr_top_s;
                end else begin
                    isr_next_s = isr;
                end
            end
            default: begin
                isr_next_s = isr;
            end
        endcase
    end

    // Previous irq sample for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= ZERO;
        end else begin
            irq_q <= irq;
        end
    end

    // Mask register; a write affects eligibility from the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= ZERO;
        end else if (mask_we) begin
            mask_r <= mask_in;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Global enable; di has precedence over a simultaneous ei.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gie <= 1'b0;
        end else if (di) begin
            gie <= 1'b0;
        end else if (ei) begin
            gie <= 1'b1;
        end else begin
            gie <= gie;
        end
    end

    // Pending latch; a fresh edge survives a take-clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= ZERO;
        end else begin
            pending <= (pending & ~clear_s) | edge_s;
        end
    end

    // Interrupt-entry FSM with registered take strobe and in-service state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            win_r   <= ZERO;
            ie      <= ZERO;
            isr     <= ZERO;
            busy    <= 1'b0;
        end else begin
            isr  <= isr_next_s;
            busy <= |isr_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (win_s != ZERO) begin
                        state_r <= ST_TAKE;
                        win_r   <= win_s;
                        ie      <= win_s;
                    end else begin
                        state_r <= ST_IDLE;
                        ie      <= ZERO;
                    end
                end
                ST_TAKE: begin
                    state_r <= ST_SERVICE;
                    ie      <= ZERO;
                end
                ST_SERVICE: begin
                    if (reti) begin
                        ie <= ZERO;
                        if (isr_next_s == ZERO) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_SERVICE;
                        end
`ifdef INT_CTRL_NEST_EN
                    end else if (preempt_s) begin
                        state_r <= ST_TAKE;
                        win_r   <= win_s;
                        ie      <= win_s;
`endif
                    end else begin
                        state_r <= ST_SERVICE;
                        ie      <= ZERO;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ie      <= ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed stimulus for int_ctrl. Expected take strobes (value
// and cycle) are queued when stimulus is issued; a negedge monitor pops and
// compares whenever ie is non-zero. State outputs are checked inline.
module tb_int_ctrl;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] irq     = 4'd0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_in = 4'd0;
    logic       ei      = 1'b0;
    logic       di      = 1'b0;
    logic       reti    = 1'b0;
    logic [3:0] ie;
    logic [3:0] isr;
    logic [3:0] pending;
    logic       gie;
    logic       busy;

    int_ctrl #(.NLINES(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .mask_we (mask_we),
        .mask_in (mask_in),
        .ei      (ei),
        .di      (di),
        .reti    (reti),
        .ie      (ie),
        .isr     (isr),
        .pending (pending),
        .gie     (gie),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] val;
        int         at;
    } exp_t;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] prev_ie = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_ie(input logic [3:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Advance to the next negedge and drop all one-cycle strobes.
    task automatic step();
        @(negedge clk);
        mask_we = 1'b0;
        ei      = 1'b0;
        di      = 1'b0;
        reti    = 1'b0;
    endtask

    // Monitor: every non-zero ie must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ie !== 4'd0) begin
            chk("ie_not_back_to_back", {28'd0, prev_ie}, 32'd0);
            if (sb.size() == 0) begin
                chk("ie_unexpected", {28'd0, ie}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ie_value", {28'd0, ie}, {28'd0, mon_e.val});
                chk("ie_cycle", cyc, mon_e.at);
            end
        end
        prev_ie = ie;
    end

    initial begin
        int c;
        step();
        step();
        chk("rst_ie", {28'd0, ie}, 32'd0);
        chk("rst_isr", {28'd0, isr}, 32'd0);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_gie", {31'd0, gie}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step();

        // Configure: all lines unmasked, global enable on.
        mask_we = 1'b1; mask_in = 4'b1111; ei = 1'b1;
        step();
        chk("gie_after_ei", {31'd0, gie}, 32'd1);

        // Basic take on line 2.
        irq = 4'b0100; c = cyc; expect_ie(4'b0100, c + 2);
        step();
        chk("basic_pending", {28'd0, pending}, 32'h4);
        step();
        step();
        chk("basic_isr", {28'd0, isr}, 32'h4);
        chk("basic_busy", {31'd0, busy}, 32'd1);
        chk("basic_pending_clr", {28'd0, pending}, 32'd0);
        reti = 1'b1; irq = 4'd0;
        step();
        chk("basic_reti_isr", {28'd0, isr}, 32'd0);
        chk("basic_reti_busy", {31'd0, busy}, 32'd0);

        // Priority: lines 1 and 3 together, line 1 first.
        irq = 4'b1010; c = cyc;
        expect_ie(4'b0010, c + 2);
        expect_ie(4'b1000, c + 5);
        step();
        chk("prio_pending", {28'd0, pending}, 32'ha);
        step();
        step();
        chk("prio_isr1", {28'd0, isr}, 32'h2);
        chk("prio_pending_left", {28'd0, pending}, 32'h8);
        reti = 1'b1;
        step();
        chk("prio_reti_isr", {28'd0, isr}, 32'd0);
        step();
        step();
        chk("prio_isr3", {28'd0, isr}, 32'h8);
        reti = 1'b1; irq = 4'd0;
        step();
        chk("prio_done_busy", {31'd0, busy}, 32'd0);

        // Masked line latches but is not taken until unmasked.
        mask_we = 1'b1; mask_in = 4'b1110;
        step();
        irq = 4'b0001;
        step();
        step();
        step();
        chk("mask_pending", {28'd0, pending}, 32'h1);
        chk("mask_no_take", {28'd0, isr}, 32'd0);
        mask_we = 1'b1; mask_in = 4'b1111; c = cyc; expect_ie(4'b0001, c + 2);
        step();
        step();
        step();
        chk("mask_isr", {28'd0, isr}, 32'h1);
        reti = 1'b1; irq = 4'd0;
        step();

        // Global enable off: no take until ei.
        di = 1'b1;
        step();
        chk("gie_after_di", {31'd0, gie}, 32'd0);
        irq = 4'b0001;
        step();
        step();
        step();
        chk("gie_pending", {28'd0, pending}, 32'h1);
        chk("gie_no_take", {31'd0, busy}, 32'd0);
        ei = 1'b1; c = cyc; expect_ie(4'b0001, c + 2);
        step();
        chk("gie_reenabled", {31'd0, gie}, 32'd1);
        step();
        step();
        chk("gie_isr", {28'd0, isr}, 32'h1);
        reti = 1'b1; irq = 4'd0;
        step();

        // ei and di together: di wins.
        ei = 1'b1; di = 1'b1;
        step();
        chk("ei_di_same", {31'd0, gie}, 32'd0);
        ei = 1'b1;
        step();

        // New edge on line 2 during its own TAKE cycle keeps it pending.
        irq = 4'b0100; c = cyc;
        expect_ie(4'b0100, c + 2);
        expect_ie(4'b0100, c + 5);
        step();
        irq = 4'd0;
        step();
        irq = 4'b0100;
        step();
        chk("set_wins_pending", {28'd0, pending}, 32'h4);
        chk("set_wins_isr", {28'd0, isr}, 32'h4);
        reti = 1'b1;
        step();
        step();
        step();
        chk("set_wins_isr2", {28'd0, isr}, 32'h4);
        chk("set_wins_pending2", {28'd0, pending}, 32'd0);
        reti = 1'b1; irq = 4'd0;
        step();
        chk("set_wins_done", {28'd0, isr}, 32'd0);

        // reti with nothing in service: no state change.
        reti = 1'b1;
        step();
        chk("idle_reti_isr", {28'd0, isr}, 32'd0);
        chk("idle_reti_pending", {28'd0, pending}, 32'd0);
        chk("idle_reti_gie", {31'd0, gie}, 32'd1);
        chk("idle_reti_busy", {31'd0, busy}, 32'd0);

        // Line 3 in service, then an edge on line 1.
        irq = 4'b1000; c = cyc; expect_ie(4'b1000, c + 2);
        step();
        step();
        step();
        chk("nest_isr3", {28'd0, isr}, 32'h8);
        irq = 4'b1010;
`ifdef INT_CTRL_NEST_EN
        expect_ie(4'b0010, c + 5);
        step();
        step();
        step();
        chk("nest_isr_both", {28'd0, isr}, 32'ha);
        reti = 1'b1;
        step();
        chk("nest_reti1", {28'd0, isr}, 32'h8);
        reti = 1'b1;
        step();
        chk("nest_reti2", {28'd0, isr}, 32'd0);
`else
        step();
        step();
        chk("nonest_isr_held", {28'd0, isr}, 32'h8);
        chk("nonest_pending", {28'd0, pending}, 32'h2);
        reti = 1'b1; expect_ie(4'b0010, c + 7);
        step();
        chk("nonest_reti1", {28'd0, isr}, 32'd0);
        step();
        step();
        chk("nonest_isr1", {28'd0, isr}, 32'h2);
        reti = 1'b1;
        step();
        chk("nonest_reti2", {28'd0, isr}, 32'd0);
`endif
        irq = 4'd0;
        step();

        // Asynchronous reset in the middle of a TAKE cycle.
        irq = 4'b0100; c = cyc; expect_ie(4'b0100, c + 2);
        step();
        step();
        chk("take_ie_before_reset", {28'd0, ie}, 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ie", {28'd0, ie}, 32'd0);
        chk("async_rst_isr", {28'd0, isr}, 32'd0);
        chk("async_rst_pending", {28'd0, pending}, 32'd0);
        chk("async_rst_gie", {31'd0, gie}, 32'd0);
        step();
        reset = 1'b0; irq = 4'd0;
        step();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
